controller_sequencer: RTL and testbench

//  Controller-sequencer for the SAP-1 datapath: the control-word source that drives the

---
 rtl/controller_sequencer.sv | 140 ++++++++++++++
 tb/tb_controller_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: a six-state one-hot ring (T1..T6) stepped on the
// falling clock edge, with the control word decoded from the ring state and
// the instruction opcode. Executing HLT latches a halt that only CLR_n clears.
module controller_sequencer #(
  parameter int                  OP_WIDTH = 4,
  parameter logic [OP_WIDTH-1:0] OP_LDA   = 4'b0000,
  parameter logic [OP_WIDTH-1:0] OP_ADD   = 4'b0001,
  parameter logic [OP_WIDTH-1:0] OP_SUB   = 4'b0010,
  parameter logic [OP_WIDTH-1:0] OP_OUT   = 4'b1110,
  parameter logic [OP_WIDTH-1:0] OP_HLT   = 4'b1111
) (
  input  logic                CLK,
  input  logic                CLR_n,
  input  logic [OP_WIDTH-1:0] opcode,
  output logic                Cp,
  output logic                Ep,
  output logic                Lm_n,
  output logic                CE_n,
  output logic                Li_n,
  output logic                Ei_n,
  output logic                La_n,
  output logic                Ea,
  output logic                Su,
  output logic                Eu,
  output logic                Lb_n,
  output logic                Lo_n,
  output logic                HLT_n,
  output logic [5:0]          t_state
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tState_e;

  tState_e state_q, state_d;
  logic    halted_q, halted_d;

  // Ring and halt flag advance on the falling edge so the datapath sees a
  // stable control word at its rising edge; CLR_n restarts at T1 at once.
  always_ff @(negedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Rotate the ring; leaving T4 with HLT parks it at T4 and sets the halt flag.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: state_d = T4;
        T4: begin
          if (opcode == OP_HLT) halted_d = 1'b1;
          else                  state_d  = T5;
        end
        T5: state_d = T6;
        T6: state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  // Decode the control word; reset and halt override the ring decode.
  always_comb begin
    Cp    = 1'b0;
    Ep    = 1'b0;
    Lm_n  = 1'b1;
    CE_n  = 1'b1;
    Li_n  = 1'b1;
    Ei_n  = 1'b1;
    La_n  = 1'b1;
    Ea    = 1'b0;
    Su    = 1'b0;
    Eu    = 1'b0;
    Lb_n  = 1'b1;
    Lo_n  = 1'b1;
    HLT_n = 1'b1;
    if (!CLR_n) begin
      HLT_n = 1'b1;
    end else if (halted_q) begin
      HLT_n = 1'b0;
    end else begin
      case (state_q)
        T1: begin
          Ep   = 1'b1;
          Lm_n = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          CE_n = 1'b0;
          Li_n = 1'b0;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            Ei_n = 1'b0;
            Lm_n = 1'b0;
          end else if (opcode == OP_OUT) begin
            Ea   = 1'b1;
            Lo_n = 1'b0;
          end else if (opcode == OP_HLT) begin
            HLT_n = 1'b0;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            CE_n = 1'b0;
            La_n = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            CE_n = 1'b0;
            Lb_n = 1'b0;
            Su   = (opcode == OP_SUB);
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            La_n = 1'b0;
            Eu   = 1'b1;
            Su   = (opcode == OP_SUB);
          end
        end
        default: HLT_n = 1'b1;
      endcase
    end
  end

  assign t_state = state_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: directed and random instructions compared
// against a step-numbered reference model of the SAP-1 control table.
module tb_controller_sequencer;

  logic       CLK;
  logic       CLR_n;
  logic [3:0] opcode;
  logic       Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n, HLT_n;
  logic [5:0] t_state;

  int vectors;
  int miscompares;

  controller_sequencer dut (
    .CLK(CLK), .CLR_n(CLR_n), .opcode(opcode),
    .Cp(Cp), .Ep(Ep), .Lm_n(Lm_n), .CE_n(CE_n), .Li_n(Li_n), .Ei_n(Ei_n),
    .La_n(La_n), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb_n(Lb_n), .Lo_n(Lo_n),
    .HLT_n(HLT_n), .t_state(t_state)
  );

  // Free-running clock; the ring steps on each falling edge.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference control word for instruction step 1..6 of opcode op,
  // packed as {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n,HLT_n}.
  function automatic logic [12:0] modelWord(int step, logic [3:0] op, bit halted, bit clrLow);
    logic cp, ep, lmN, ceN, liN, eiN, laN, ea, su, eu, lbN, loN, hltN;
    cp = 0; ep = 0; lmN = 1; ceN = 1; liN = 1; eiN = 1; laN = 1;
    ea = 0; su = 0; eu = 0; lbN = 1; loN = 1; hltN = 1;
    if (clrLow) begin
      hltN = 1;
    end else if (halted) begin
      hltN = 0;
    end else if (step == 1) begin
      ep = 1; lmN = 0;
    end else if (step == 2) begin
      cp = 1;
    end else if (step == 3) begin
      ceN = 0; liN = 0;
    end else if (step == 4) begin
      if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) begin eiN = 0; lmN = 0; end
      if (op == 4'b1110) begin ea = 1; loN = 0; end
      if (op == 4'b1111) hltN = 0;
    end else if (step == 5) begin
      if (op == 4'b0000) begin ceN = 0; laN = 0; end
      if (op == 4'b0001 || op == 4'b0010) begin ceN = 0; lbN = 0; end
      if (op == 4'b0010) su = 1;
    end else if (step == 6) begin
      if (op == 4'b0001 || op == 4'b0010) begin laN = 0; eu = 1; end
      if (op == 4'b0010) su = 1;
    end
    return {cp, ep, lmN, ceN, liN, eiN, laN, ea, su, eu, lbN, loN, hltN};
  endfunction

  function automatic logic [18:0] modelVector(int step, logic [3:0] op, bit halted, bit clrLow);
    logic [5:0] ring;
    ring = 6'd1 << (step - 1);
    return {ring, modelWord(step, op, halted, clrLow)};
  endfunction

  function automatic logic [18:0] dutVector();
    return {t_state, Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n, HLT_n};
  endfunction

  // Single comparison point: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [18:0] observed, input logic [18:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%05h required=%05h (t_state,Cp..HLT_n)", tag, observed, expected);
    end
  endtask

  // At most one bus driver may be enabled at a time.
  task automatic checkBus(input string tag);
    int drivers;
    drivers = int'(Ep) + int'(~CE_n) + int'(~Ei_n) + int'(Ea) + int'(Eu);
    checkOutput(tag, 19'(drivers <= 1), 19'd1);
  endtask

  // Runs one whole instruction starting in T1, just after a rising edge.
  task automatic applyStimulus(input logic [3:0] op, input string name);
    for (int step = 1; step <= 6; step++) begin
      checkOutput($sformatf("%s_T%0d", name, step), dutVector(), modelVector(step, op, 0, 0));
      checkBus($sformatf("%s_bus_T%0d", name, step));
      if (step == 1) opcode = op;
      @(negedge CLK);
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    logic [3:0] op;
    vectors     = 0;
    miscompares = 0;
    CLR_n       = 1'b0;
    opcode      = 4'b0000;

    // Reset held across several edges, then released between edges.
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1;
    checkOutput("reset_hold", dutVector(), modelVector(1, opcode, 0, 1));
    CLR_n = 1'b1;
    #1;
    checkOutput("reset_release", dutVector(), modelVector(1, opcode, 0, 0));

    applyStimulus(4'b0000, "LDA");
    checkOutput("LDA_wrap", {t_state, 13'd0}, {6'b000001, 13'd0});
    applyStimulus(4'b0001, "ADD");
    applyStimulus(4'b0010, "SUB");
    applyStimulus(4'b1110, "OUT");

    // ADD interrupted by reset in T5: ring snaps to T1 without a clock edge.
    for (int step = 1; step <= 5; step++) begin
      checkOutput($sformatf("ADDrst_T%0d", step), dutVector(), modelVector(step, 4'b0001, 0, 0));
      if (step == 1) opcode = 4'b0001;
      if (step < 5) begin
        @(negedge CLK);
        @(posedge CLK);
        #1;
      end
    end
    CLR_n = 1'b0;
    #1;
    checkOutput("midreset_low", dutVector(), modelVector(1, opcode, 0, 1));
    CLR_n = 1'b1;
    #1;
    checkOutput("midreset_release", dutVector(), modelVector(1, opcode, 0, 0));

    applyStimulus(4'b0101, "NOP5");

    // Random non-halting instruction stream.
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 14));
      applyStimulus(op, $sformatf("rnd%0d_op%0h", i, op));
    end

    // HLT: request in T4, then the ring freezes at T4 with HLT_n held low.
    for (int step = 1; step <= 4; step++) begin
      checkOutput($sformatf("HLT_T%0d", step), dutVector(), modelVector(step, 4'b1111, 0, 0));
      if (step == 1) opcode = 4'b1111;
      @(negedge CLK);
      if (step < 4) begin
        @(posedge CLK);
        #1;
      end
    end
    for (int e = 0; e < 10; e++) begin
      #1;
      checkOutput($sformatf("halted_%0d", e), dutVector(), modelVector(4, 4'b1111, 1, 0));
      opcode = 4'($urandom_range(0, 15));
      @(negedge CLK);
    end
    #1;
    CLR_n = 1'b0;
    #1;
    checkOutput("halt_clear_low", dutVector(), modelVector(1, opcode, 0, 1));
    CLR_n = 1'b1;
    #1;
    checkOutput("halt_clear_release", dutVector(), modelVector(1, opcode, 0, 0));
    @(posedge CLK);
    #1;
    applyStimulus(4'b0010, "SUB_after_halt");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
